// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
// Handshake bundle for the iterative divider.
//   in_valid / in_ready   : operand handshake (producer -> divider)
//   lop / rop             : dividend / divisor, WIDTH bits, unsigned
//   out_valid / out_ready : result handshake (divider -> consumer)
//   quot / mod            : quotient / remainder, WIDTH bits
//   div_zero              : result was produced by a zero divisor
//   busy                  : divider is not idle
// master : the side issuing operands and consuming results
// slave  : the divider itself
// ---------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] lop;
    logic [WIDTH-1:0] rop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] mod;
    logic             div_zero;
    logic             busy;

    modport master (
        output in_valid, lop, rop, out_ready,
        input  in_ready, out_valid, quot, mod, div_zero, busy
    );

    modport slave (
        input  in_valid, lop, rop, out_ready,
        output in_ready, out_valid, quot, mod, div_zero, busy
    );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative unsigned restoring divider, BITS_PER_CYCLE quotient bits per
// clock, one operation in flight.
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high; discards any in-flight operation
//   bus   : seq_divider_if.slave (operand and result handshakes, status)
// A zero divisor skips iteration and completes on the accept edge with
// quot = all ones, mod = dividend, div_zero = 1. Otherwise the result is
// presented N = WIDTH/BITS_PER_CYCLE edges after the accept edge and held
// until out_ready is seen.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("seq_divider: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dividend;   // remaining dividend bits, consumed MSB first
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_rem;        // partial remainder, one spare bit
    logic [WIDTH-1:0] r_quot_acc;   // quotient bits accumulate at the LSB
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_mod;
    logic             r_div_zero;
    logic             r_out_valid;

    // Restoring step chain: stage gi feeds stage gi+1 within one clock.
    logic [WIDTH:0]            w_rem [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0]          w_dvd [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0]          w_quo [0:BITS_PER_CYCLE];
    // Bits that fall off the top of each stage; collected so they are consumed.
    logic [BITS_PER_CYCLE-1:0] w_unused_msbs;

    assign w_rem[0] = r_rem;
    assign w_dvd[0] = r_dividend;
    assign w_quo[0] = r_quot_acc;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [WIDTH:0] w_shift;
            logic           w_ge;

            // Remainder is always < divisor after a step, so its top bit is
            // zero and the shifted value fits in WIDTH+1 bits without loss.
            assign w_shift         = {w_rem[gi][WIDTH-1:0], w_dvd[gi][WIDTH-1]};
            assign w_ge            = (w_shift >= {1'b0, r_divisor});
            assign w_rem[gi+1]     = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
            assign w_dvd[gi+1]     = {w_dvd[gi][WIDTH-2:0], 1'b0};
            assign w_quo[gi+1]     = {w_quo[gi][WIDTH-2:0], w_ge};
            assign w_unused_msbs[gi] = w_rem[gi][WIDTH] ^ w_quo[gi][WIDTH-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quot_acc  <= '0;
            r_count     <= '0;
            r_quot      <= '0;
            r_mod       <= '0;
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.rop == '0) begin
                            r_state     <= S_DONE;
                            r_quot      <= '1;
                            r_mod       <= bus.lop;
                            r_div_zero  <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= S_BUSY;
                            r_dividend <= bus.lop;
                            r_divisor  <= bus.rop;
                            r_rem      <= '0;
                            r_quot_acc <= '0;
                            r_count    <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_dividend <= w_dvd[BITS_PER_CYCLE];
                    r_rem      <= w_rem[BITS_PER_CYCLE];
                    r_quot_acc <= w_quo[BITS_PER_CYCLE];
                    r_count    <= r_count + CNT_W'(1);
                    if (r_count == LAST_COUNT) begin
                        r_state     <= S_DONE;
                        r_quot      <= w_quo[BITS_PER_CYCLE];
                        r_mod       <= w_rem[BITS_PER_CYCLE][WIDTH-1:0];
                        r_div_zero  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.quot      = r_quot;
    assign bus.mod       = r_mod;
    assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Two divider instances on one clock: 8-bit/1 bit per cycle and
// 16-bit/2 bits per cycle. Expected results come from plain integer / and %.
// ---------------------------------------------------------------------------
module tb_seq_divider;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    seq_divider_if #(.WIDTH(8))  if8 ();
    seq_divider_if #(.WIDTH(16)) if16 ();

    seq_divider #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_quot(input int sel);
        return (sel != 0) ? if16.quot : {8'h00, if8.quot};
    endfunction
    function automatic logic [15:0] rd_mod(input int sel);
        return (sel != 0) ? if16.mod : {8'h00, if8.mod};
    endfunction
    function automatic logic rd_out_valid(input int sel);
        return (sel != 0) ? if16.out_valid : if8.out_valid;
    endfunction
    function automatic logic rd_in_ready(input int sel);
        return (sel != 0) ? if16.in_ready : if8.in_ready;
    endfunction
    function automatic logic rd_busy(input int sel);
        return (sel != 0) ? if16.busy : if8.busy;
    endfunction
    function automatic logic rd_div_zero(input int sel);
        return (sel != 0) ? if16.div_zero : if8.div_zero;
    endfunction

    task automatic drive_in(input int sel, input logic v, input int unsigned a, input int unsigned b);
        if (sel != 0) begin
            if16.in_valid = v;
            if16.lop      = a[15:0];
            if16.rop      = b[15:0];
        end else begin
            if8.in_valid = v;
            if8.lop      = a[7:0];
            if8.rop      = b[7:0];
        end
    endtask

    task automatic set_oready(input int sel, input logic v);
        if (sel != 0) if16.out_ready = v;
        else          if8.out_ready  = v;
    endtask

    task automatic check_reset_state(input int sel, input string pfx);
        check({pfx, " out_valid"}, rd_out_valid(sel), 0);
        check({pfx, " quot"},      rd_quot(sel),      0);
        check({pfx, " mod"},       rd_mod(sel),       0);
        check({pfx, " div_zero"},  rd_div_zero(sel),  0);
        check({pfx, " busy"},      rd_busy(sel),      0);
        check({pfx, " in_ready"},  rd_in_ready(sel),  1);
    endtask

    // One full transaction: accept, wait for result, optional backpressure,
    // output handshake, return to idle.
    task automatic run_op(input int sel, input int unsigned a, input int unsigned b, input int hold);
        int          w;
        int unsigned mask;
        int unsigned exp_q;
        int unsigned exp_m;
        int unsigned exp_dz;
        int          exp_lat;
        int          lat;
        string       nm;

        w    = (sel != 0) ? 16 : 8;
        mask = (32'd1 << w) - 32'd1;
        a    = a & mask;
        b    = b & mask;
        nm   = $sformatf("w%0d %0d/%0d", w, a, b);

        // Reference: plain integer division; zero divisor gives all ones / dividend.
        if (b == 0) begin
            exp_q   = mask;
            exp_m   = a;
            exp_dz  = 1;
            exp_lat = 0;   // result already visible after the accept edge
        end else begin
            exp_q   = a / b;
            exp_m   = a % b;
            exp_dz  = 0;
            exp_lat = 8;   // WIDTH/BITS_PER_CYCLE edges after the accept edge
        end

        check({nm, " in_ready before"}, rd_in_ready(sel), 1);
        drive_in(sel, 1'b1, a, b);
        set_oready(sel, hold == 0);
        tick();
        // Operands change after accept; the divider must ignore them.
        drive_in(sel, 1'b0, $urandom, $urandom);
        check({nm, " busy after accept"},     rd_busy(sel),     1);
        check({nm, " in_ready after accept"}, rd_in_ready(sel), 0);

        lat = 0;
        while (!rd_out_valid(sel) && lat < 40) begin
            tick();
            lat++;
        end
        check({nm, " latency"},  lat,              exp_lat);
        check({nm, " quot"},     rd_quot(sel),     exp_q);
        check({nm, " mod"},      rd_mod(sel),      exp_m);
        check({nm, " div_zero"}, rd_div_zero(sel), exp_dz);

        for (int h = 0; h < hold; h++) begin
            tick();
            check({nm, " held out_valid"}, rd_out_valid(sel), 1);
            check({nm, " held quot"},      rd_quot(sel),      exp_q);
            check({nm, " held mod"},       rd_mod(sel),       exp_m);
            check({nm, " held in_ready"},  rd_in_ready(sel),  0);
            check({nm, " held busy"},      rd_busy(sel),      1);
        end

        set_oready(sel, 1'b1);
        tick();
        set_oready(sel, 1'b0);
        check({nm, " out_valid after handshake"}, rd_out_valid(sel), 0);
        check({nm, " in_ready after handshake"},  rd_in_ready(sel),  1);
        check({nm, " busy after handshake"},      rd_busy(sel),      0);

        $display("op %s -> quot=%0d mod=%0d div_zero=%0d latency=%0d hold=%0d",
                 nm, rd_quot(sel), rd_mod(sel), rd_div_zero(sel), lat, hold);
    endtask

    initial begin
        int          stale;
        int          sel;
        int          w;
        int unsigned mask;
        int unsigned a;
        int unsigned b;
        int          kind;

        reset = 1'b1;
        drive_in(0, 1'b0, 0, 0);
        drive_in(1, 1'b0, 0, 0);
        set_oready(0, 1'b0);
        set_oready(1, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        check_reset_state(0, "reset w8");
        check_reset_state(1, "reset w16");

        // Basic operation with out_ready already high.
        run_op(0, 200, 7, 0);
        // Back-to-back corner cases, including divisor with MSB set.
        run_op(0, 255, 1, 0);
        run_op(0, 5, 9, 0);
        run_op(0, 200, 129, 0);
        // Divide by zero, then a normal op.
        run_op(0, 100, 0, 0);
        run_op(0, 9, 3, 0);
        // Backpressure for five cycles.
        run_op(0, 77, 5, 5);

        // Reset on the third BUSY edge: result must be discarded.
        check("reset-mid in_ready before", rd_in_ready(0), 1);
        drive_in(0, 1'b1, 200, 7);
        set_oready(0, 1'b1);
        tick();
        drive_in(0, 1'b0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state(0, "reset-mid w8");
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rd_out_valid(0)) stale++;
        end
        set_oready(0, 1'b0);
        check("reset-mid stale out_valid cycles", stale, 0);
        $display("op w8 200/7 aborted by reset, stale result cycles=%0d", stale);
        run_op(0, 50, 6, 0);

        // Wide instance, two quotient bits per cycle.
        run_op(1, 50000, 300, 0);
        run_op(1, 16'hFFFE, 16'hFFFF, 0);
        run_op(1, 1234, 0, 2);

        // Randomized operations on both instances.
        for (int i = 0; i < 40; i++) begin
            sel  = $urandom_range(0, 1);
            w    = (sel != 0) ? 16 : 8;
            mask = (32'd1 << w) - 32'd1;
            a    = $urandom & mask;
            kind = $urandom_range(0, 9);
            if (kind == 0)      b = 0;
            else if (kind == 1) b = (32'd1 << (w - 1)) | ($urandom & mask);
            else if (kind == 2) b = $urandom_range(1, 3);
            else                b = $urandom & mask;
            run_op(sel, a, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider, generalised in operand width and bits-retired-per-cycle.
- Sequential successor to the combinational 8-bit divider: one operation in flight, valid/ready handshake on input and output.
- Explicit divide-by-zero reporting.
- Used wherever quotient/modulo of redundancy-controller indices is needed without a WIDTH-deep combinational chain.

Parameters:
- WIDTH, 8, operand/quotient/modulo width in bits (>=2).
- BITS_PER_CYCLE, 1, quotient bits produced per clock. Must divide WIDTH; an illegal value is an elaboration error.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- lop  input  WIDTH  dividend (unsigned)
- rop  input  WIDTH  divisor (unsigned)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quot  output  WIDTH  quotient
- mod  output  WIDTH  remainder
- div_zero  output  1  result came from rop==0
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, DONE. N = WIDTH/BITS_PER_CYCLE iterations.
- Reset (sync, active-high):
  - state=IDLE, out_valid=0, quot=0, mod=0, div_zero=0, busy=0, iteration counter=0.
  - Reset overrides every other event, including reset mid-BUSY and reset in DONE. Any in-flight result is discarded and never presented.
- in_ready = (state==IDLE), combinational from state only. There is no accept in BUSY or DONE.
- Accept on an edge where in_valid && in_ready:
  - rop!=0: latch dividend=lop, divisor=rop, partial remainder=0, counter=0; go to BUSY.
  - rop==0: go directly to DONE with quot = all ones, mod = lop, div_zero=1. Latency 1 edge.
- BUSY, each edge performs BITS_PER_CYCLE restoring steps combinationally chained, MSB first. Per step:
  - r = {r[WIDTH-1:0], next dividend MSB}; dividend shifts left by 1.
  - If r >= divisor: r = r - divisor, quotient bit = 1; else quotient bit = 0.
  - Quotient bits shift in at the LSB.
- Partial remainder register is WIDTH+1 bits, so no truncation occurs for divisors with MSB set (rop > 2^(WIDTH-1) must work). mod is the low WIDTH bits of the final r.
- Counter increments per edge in BUSY. On the edge where counter reaches N-1, go to DONE, load quot/mod, set out_valid=1, div_zero=0.
- Latency: out_valid visible exactly N edges after the accept edge. For WIDTH=8, BITS_PER_CYCLE=1 that is 8.
- DONE:
  - out_valid=1; quot, mod, div_zero held stable for as long as out_ready=0 (unlimited backpressure).
  - On an edge with out_ready=1: out_valid=0, go to IDLE. in_ready rises the cycle after.
  - quot/mod/div_zero keep their last values after handshake; they are only meaningful while out_valid=1.
- lop/rop are ignored outside the accept edge; changes during BUSY have no effect.
- out_ready is ignored while out_valid=0.
- busy = (state != IDLE).
- Throughput: one result per N+2 cycles minimum (accept, N iterations, output handshake, return to IDLE).

Test Plan:
- WIDTH=8, BPC=1: lop=200, rop=7, out_ready=1 -> out_valid 8 edges after accept, quot=28, mod=4, div_zero=0. in_ready high again 1 cycle after the output handshake.
- WIDTH=8: back-to-back 255/1 -> quot=255, mod=0. Then 5/9 -> quot=0, mod=5. Then 200/129 (divisor MSB set) -> quot=1, mod=71.
- WIDTH=8: lop=100, rop=0 -> out_valid 1 edge after accept, quot=255, mod=100, div_zero=1. Next op 9/3 -> quot=3, mod=0, div_zero=0.
- Backpressure: 77/5 with out_ready held low 5 cycles after out_valid -> quot=15, mod=2 stable throughout, in_ready=0, busy=1. Raising out_ready -> out_valid=0 next edge, then IDLE.
- Reset mid-op: assert reset on the 3rd BUSY edge of 200/7 -> out_valid never asserts, all outputs 0, in_ready=1 the cycle after reset deasserts. A following 50/6 gives quot=8, mod=2.
- WIDTH=16, BPC=2: lop=50000, rop=300 -> out_valid 8 edges after accept, quot=166, mod=200. rop=0xFFFF, lop=0xFFFE -> quot=0, mod=0xFFFE.
